// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_result_t;

endpackage

// File: rtl/fetch.sv
// Instruction-fetch stage: one word read per start pulse from a fixed-latency memory.
// Optional FETCH_MISALIGN_CHECK_EN turns unaligned start PCs into an immediate illegal result.
module fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enabled,
    input  logic [31:0]       pc_in,
    input  logic              flush,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              completed,
    output logic [31:0]       pc,
    output logic [31:0]       instr_raw,
    output logic              misaligned
);

    fetch_state_t      state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              done, done_d;
    fetch_result_t     res, res_d;
    logic              en_d;
    logic [ADDR_W-1:0] addr_d;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_q, mis_d;
    logic mis_pend, mis_pend_d;
`endif

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            res       <= '0;
            imem_en   <= 1'b0;
            imem_addr <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            done      <= done_d;
            res       <= res_d;
            imem_en   <= en_d;
            imem_addr <= addr_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mis_q    <= 1'b0;
            mis_pend <= 1'b0;
        end else begin
            mis_q    <= mis_d;
            mis_pend <= mis_pend_d;
        end
    end
`endif

    // Next-state logic; a start pulse overrides flush and any fetch in progress
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        done_d  = done;
        res_d   = res;
        en_d    = 1'b0;
        addr_d  = imem_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_d      = mis_q;
        mis_pend_d = mis_pend;
`endif
        if (enabled) begin
            res_d.pc = pc_in;
            addr_d   = pc_in[ADDR_W+1:2];
            done_d   = 1'b0;
            state_d  = WAIT;
            cnt_d    = CNT_W'(MEM_LATENCY);
            en_d     = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_d      = 1'b0;
            mis_pend_d = 1'b0;
            // Unaligned PC: no memory request, resolve on the very next edge
            if (pc_in[1:0] != 2'b00) begin
                en_d       = 1'b0;
                cnt_d      = '0;
                mis_pend_d = 1'b1;
            end
`endif
        end else if (flush) begin
            state_d = IDLE;
            done_d  = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_d      = 1'b0;
            mis_pend_d = 1'b0;
`endif
        end else begin
            case (state)
                WAIT: begin
                    if (cnt != '0) begin
                        cnt_d = cnt - CNT_W'(1);
                    end else begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        res_d.instr = imem_rdata;
`ifdef FETCH_MISALIGN_CHECK_EN
                        if (mis_pend) begin
                            res_d.instr = '0;
                            mis_d       = 1'b1;
                            mis_pend_d  = 1'b0;
                        end
`endif
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Result is withdrawn in the same cycle a new fetch is requested
    assign completed = done & ~enabled;
    assign pc        = res.pc;
    assign instr_raw = res.instr;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = mis_q;
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
Instruction-fetch stage directly upstream of the decode stage.
- On a one-cycle start pulse, latches the target PC and issues a single word read to a fixed-latency instruction memory (BRAM-style, pipelined).
- Captures the returned word and presents `pc`/`instr_raw` to decode with the `completed` convention used across the core stages.
- Supports flush (redirect abort) and restart mid-fetch.

Parameters:
- ADDR_W, 14, width of the instruction-memory word address (memory depth 2^ADDR_W words).
- MEM_LATENCY, 1, cycles from the edge where memory samples `imem_en` to the edge where `imem_rdata` is valid; legal 1..15.

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- enabled  in  1  start pulse; samples `pc_in`.
- pc_in  in  32  byte address to fetch.
- flush  in  1  abort any fetch in progress.
- imem_en  out  1  memory read enable.
- imem_addr  out  ADDR_W  word address, equal to `pc_in[ADDR_W+1:2]`.
- imem_rdata  in  32  memory read data.
- completed  out  1  fetch result valid.
- pc  out  32  PC of the held instruction.
- instr_raw  out  32  fetched instruction word.
- misaligned  out  1  fetch PC not word aligned (optional feature; otherwise 0).

Behaviour:
- One clock: `clk`. Reset is `rstn`, asynchronous and active-low.
- On reset, outputs and state take these values:
  - state=IDLE
  - imem_en=0, imem_addr=0
  - pc=0, instr_raw=0
  - internal done=0, so completed=0
  - misaligned=0
  - latency counter=0
- Reset asserted mid-fetch returns the block to IDLE immediately; any in-flight memory data is never captured.
- States are IDLE, WAIT and DONE, encoded as a 2-bit enum.
- enabled high at edge T, in any state:
  - pc<=pc_in; imem_addr<=pc_in[ADDR_W+1:2]; imem_en<=1
  - cnt<=MEM_LATENCY; done<=0; state<=WAIT
- imem_en is high for exactly the one cycle after T and is cleared at T+1.
- WAIT:
  - Each edge with cnt!=0 decrements cnt.
  - At the edge with cnt==0: instr_raw<=imem_rdata; done<=1; state<=DONE.
  - Capture happens at edge T+1+MEM_LATENCY; completed is visible after T+1+MEM_LATENCY (MEM_LATENCY=1 gives 2 cycles).
- DONE:
  - pc and instr_raw hold stable until the next enabled.
  - done stays 1.
- completed = done & !enabled (combinational). It drops in the same cycle a new fetch is requested.
- flush high with enabled low: state<=IDLE, done<=0, imem_en<=0. pc and instr_raw keep their old values but completed=0.
- flush and enabled at the same edge: enabled wins and a new fetch starts from pc_in.
- enabled during WAIT restarts the fetch. The old request is discarded, and the counter guarantees only data for the new address is captured.
- enabled while IDLE or DONE behaves as a normal start.
- imem_addr ignores pc_in[1:0] and pc_in[31:ADDR_W+2]; the high bits wrap silently.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined:
  - enabled with pc_in[1:0]!=0 issues no memory request (imem_en stays 0).
  - Next edge: state<=DONE, done<=1, instr_raw<=32'h0, misaligned<=1.
  - Decode then flags the word illegal.
  - misaligned clears on the next enabled or flush.
- Undefined:
  - misaligned is tied 0.
  - pc_in[1:0] is ignored and the fetch proceeds normally.

Decomposition:
- Shared package (def.sv):
  - typedef enum logic [1:0] fetch_state_t {IDLE, WAIT, DONE}
  - localparam INSTR_NOP = 32'h00000013, used by benches and by the flush-bubble logic in the core
- No sub-module; the latency counter and FSM are small enough to stay in fetch.

Test Plan:
1. Reset release, enabled with pc_in=0x100 and MEM_LATENCY=1, memory word 0x00A00093 -> imem_en pulses 1 cycle with imem_addr=0x40; completed=1 two cycles after the enabled edge; pc=0x100; instr_raw=0x00A00093.
2. MEM_LATENCY=4, pc_in=0x8 -> completed rises exactly 5 cycles after the enabled edge; no early capture.
3. enabled with pc=0x10, then enabled again with pc=0x20 one cycle later (MEM_LATENCY=3) -> only the word at 0x20 is captured; pc=0x20; completed appears once.
4. flush during WAIT -> completed stays 0 and state returns to IDLE. Separately, flush and enabled (pc_in=0x40) at the same edge -> fetch of 0x40 completes normally.
5. rstn pulled low while in WAIT -> all outputs are 0 asynchronously; after release, completed stays 0 until the next enabled.
6. FETCH_MISALIGN_CHECK_EN defined, pc_in=0x102 -> imem_en never asserts; after 1 cycle completed=1, misaligned=1, instr_raw=0. With the macro undefined -> normal fetch from word 0x40 and misaligned=0.
